uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 109 ++++++++++
 tb/tb_uart_tx_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a UART transmitter core.
// Latches the winning byte, strobes load/ack once, then tracks frame and gap bit periods via txen.
module uart_tx_arb #(
  parameter int FRAME_BITS = 10,
  parameter int GAP_BITS   = 1
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic       txen_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       load_o,
  output logic [7:0] tx_data_o,
  output logic       busy_o,
  output logic       grant_o
);

  localparam int MaxBits = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int CntW    = $clog2(MaxBits + 1);
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0] GapLast   = (GAP_BITS > 0) ? CntW'(GAP_BITS - 1) : '0;

  typedef enum logic [1:0] {
    Idle,
    Load,
    Send,
    Gap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] bitCnt_q, bitCnt_d;
  logic [7:0]      txData_q, txData_d;
  logic            grant_q, grant_d;
  logic            winner;

  // Grant resets to 1 so requester 0 wins the first contention after reset.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q  <= Idle;
      bitCnt_q <= '0;
      txData_q <= 8'h00;
      grant_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      txData_q <= txData_d;
      grant_q  <= grant_d;
    end
  end

  // Strobes during selection and LOAD are deliberately ignored; counting starts in SEND.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    txData_d = txData_q;
    grant_d  = grant_q;
    winner   = grant_q;
    case (state_q)
      Idle: begin
        if (req0_i || req1_i) begin
          winner   = (req0_i && req1_i) ? ~grant_q : req1_i;
          grant_d  = winner;
          txData_d = winner ? data1_i : data0_i;
          state_d  = Load;
        end
      end
      Load: begin
        bitCnt_d = '0;
        state_d  = Send;
      end
      Send: begin
        if (txen_i) begin
          if (bitCnt_q == FrameLast) begin
            bitCnt_d = '0;
            state_d  = (GAP_BITS > 0) ? Gap : Idle;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      Gap: begin
        if (txen_i) begin
          if (bitCnt_q == GapLast) begin
            bitCnt_d = '0;
            state_d  = Idle;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: begin
        bitCnt_d = '0;
        state_d  = Idle;
      end
    endcase
  end

  assign load_o    = (state_q == Load);
  assign ack0_o    = load_o && !grant_q;
  assign ack1_o    = load_o && grant_q;
  assign busy_o    = (state_q != Idle);
  assign tx_data_o = txData_q;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: instance A uses default parameters, instance B has no idle gap.
// Every cycle advances through tick(), which also paces txen as one strobe every third cycle.
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       txen = 1'b0;
  logic       req0A = 1'b0, req1A = 1'b0, req0B = 1'b0, req1B = 1'b0;
  logic [7:0] data0A = 8'h00, data1A = 8'h00, data0B = 8'h00, data1B = 8'h00;
  logic       ack0A, ack1A, loadA, busyA, grantA;
  logic       ack0B, ack1B, loadB, busyB, grantB;
  logic [7:0] txDataA, txDataB;

  int compared   = 0;
  int mismatched = 0;
  int phase      = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.FRAME_BITS(10), .GAP_BITS(1)) dutA (
    .clk_i(clk), .n_rst_i(nRst), .txen_i(txen),
    .req0_i(req0A), .req1_i(req1A), .data0_i(data0A), .data1_i(data1A),
    .ack0_o(ack0A), .ack1_o(ack1A), .load_o(loadA), .tx_data_o(txDataA),
    .busy_o(busyA), .grant_o(grantA)
  );

  uart_tx_arb #(.FRAME_BITS(10), .GAP_BITS(0)) dutB (
    .clk_i(clk), .n_rst_i(nRst), .txen_i(txen),
    .req0_i(req0B), .req1_i(req1B), .data0_i(data0B), .data1_i(data1B),
    .ack0_o(ack0B), .ack1_o(ack1B), .load_o(loadB), .tx_data_o(txDataB),
    .busy_o(busyB), .grant_o(grantB)
  );

  // Advance one cycle; outputs are then stable for sampling and new inputs apply at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase == 2) ? 0 : phase + 1;
    txen  = (phase == 0);
  endtask

  task automatic applyStimulus(input bit useB, input logic r0, input logic r1,
                               input logic [7:0] d0, input logic [7:0] d1);
    if (useB) begin
      req0B = r0; req1B = r1; data0B = d0; data1B = d1;
    end else begin
      req0A = r0; req1A = r1; data0A = d0; data1A = d1;
    end
  endtask

  task automatic doReset();
    nRst = 1'b0;
    tick();
    tick();
    nRst = 1'b1;
  endtask

  task automatic waitLoad(input bit useB, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (useB ? loadB : loadA) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  // Called from the LOAD cycle; returns in the first IDLE cycle with the strobes seen while busy.
  task automatic runFrame(input bit useB, output int strobes, output int loads,
                          output int acks, output bit timedOut);
    strobes  = 0;
    loads    = 0;
    acks     = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!(useB ? busyB : busyA)) begin
        timedOut = 1'b0;
        return;
      end
      if (txen) strobes++;
      if (useB ? loadB : loadA) loads++;
      if (useB ? (ack0B || ack1B) : (ack0A || ack1A)) acks++;
    end
  endtask

  task automatic test_reset();
    applyStimulus(0, 0, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00);
    nRst = 1'b0;
    tick(); tick(); tick();
    compared++; if (busyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
    compared++; if (loadA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load: got %b want 0", loadA); end
    compared++; if ({ack0A, ack1A} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_acks: got %b want 00", {ack0A, ack1A}); end
    compared++; if (txDataA !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_txdata: got %h want 00", txDataA); end
    compared++; if (grantA !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_grant: got %b want 1", grantA); end
    compared++; if (busyB !== 1'b0 || grantB !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_B: got busy=%b grant=%b want 0/1", busyB, grantB); end
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int s, l, a; bit to;
    applyStimulus(0, 1, 0, 8'hA5, 8'h00);
    tick();
    compared++; if (loadA !== 1'b1) begin mismatched++; $display("[TB] FAIL single_load: got %b want 1", loadA); end
    compared++; if ({ack0A, ack1A} !== 2'b10) begin mismatched++; $display("[TB] FAIL single_acks: got %b want 10", {ack0A, ack1A}); end
    compared++; if (txDataA !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_txdata: got %h want a5", txDataA); end
    compared++; if (busyA !== 1'b1 || grantA !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy_grant: got %b/%b want 1/0", busyA, grantA); end
    applyStimulus(0, 0, 0, 8'hA5, 8'h00);
    runFrame(0, s, l, a, to);
    compared++; if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL single_timeout: busy never dropped"); end
    compared++; if (s !== 11) begin mismatched++; $display("[TB] FAIL single_strobes: got %0d want 11", s); end
    compared++; if (l !== 0 || a !== 0) begin mismatched++; $display("[TB] FAIL single_extra: got loads=%0d acks=%0d want 0/0", l, a); end
    compared++; if (txDataA !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_hold: got %h want a5", txDataA); end
  endtask

  task automatic test_contention();
    int s, l, a; bit to;
    doReset();
    applyStimulus(0, 1, 1, 8'h11, 8'h22);
    tick();
    compared++; if ({loadA, ack0A, ack1A} !== 3'b110) begin mismatched++; $display("[TB] FAIL cont_first_ack: got %b want 110", {loadA, ack0A, ack1A}); end
    compared++; if (txDataA !== 8'h11) begin mismatched++; $display("[TB] FAIL cont_first_data: got %h want 11", txDataA); end
    applyStimulus(0, 0, 1, 8'h11, 8'h22);
    runFrame(0, s, l, a, to);
    compared++; if (to !== 1'b0 || s !== 11) begin mismatched++; $display("[TB] FAIL cont_first_frame: got strobes=%0d timeout=%b want 11/0", s, to); end
    tick();
    compared++; if ({loadA, ack0A, ack1A} !== 3'b101) begin mismatched++; $display("[TB] FAIL cont_second_ack: got %b want 101", {loadA, ack0A, ack1A}); end
    compared++; if (txDataA !== 8'h22) begin mismatched++; $display("[TB] FAIL cont_second_data: got %h want 22", txDataA); end
    applyStimulus(0, 0, 0, 8'h11, 8'h22);
    runFrame(0, s, l, a, to);
    compared++; if (to !== 1'b0 || grantA !== 1'b1) begin mismatched++; $display("[TB] FAIL cont_end_grant: got grant=%b timeout=%b want 1/0", grantA, to); end
  endtask

  task automatic test_fairness();
    int s, l, a; bit to, found;
    logic [3:0] expGrant;
    expGrant = 4'b1010;
    applyStimulus(0, 1, 1, 8'h33, 8'h44);
    for (int k = 0; k < 4; k++) begin
      waitLoad(0, 80, found);
      compared++; if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL fair_load%0d: no load seen", k); end
      compared++; if (grantA !== expGrant[k]) begin mismatched++; $display("[TB] FAIL fair_grant%0d: got %b want %b", k, grantA, expGrant[k]); end
      compared++; if (txDataA !== (expGrant[k] ? 8'h44 : 8'h33)) begin mismatched++; $display("[TB] FAIL fair_data%0d: got %h", k, txDataA); end
    end
    applyStimulus(0, 0, 0, 8'h33, 8'h44);
    runFrame(0, s, l, a, to);
    compared++; if (to !== 1'b0 || s !== 11) begin mismatched++; $display("[TB] FAIL fair_last_frame: got strobes=%0d timeout=%b want 11/0", s, to); end
  endtask

  task automatic test_busy_reject();
    int s, l, a; bit to, pulsed;
    s = 0; l = 0; a = 0; to = 1'b1; pulsed = 1'b0;
    applyStimulus(0, 1, 0, 8'h5A, 8'hC7);
    tick();
    compared++; if ({loadA, ack0A, ack1A} !== 3'b110) begin mismatched++; $display("[TB] FAIL rej_ack: got %b want 110", {loadA, ack0A, ack1A}); end
    applyStimulus(0, 0, 0, 8'h5A, 8'hC7);
    for (int i = 0; i < 300; i++) begin
      tick();
      req1A = 1'b0;
      if (!busyA) begin to = 1'b0; break; end
      if (txen) s++;
      if (loadA) l++;
      if (ack0A || ack1A) a++;
      if (s == 3 && !pulsed) begin req1A = 1'b1; pulsed = 1'b1; end
    end
    compared++; if (to !== 1'b0 || s !== 11) begin mismatched++; $display("[TB] FAIL rej_strobes: got %0d timeout=%b want 11/0", s, to); end
    compared++; if (l !== 0 || a !== 0) begin mismatched++; $display("[TB] FAIL rej_ack_load: got loads=%0d acks=%0d want 0/0", l, a); end
    compared++; if (txDataA !== 8'h5A || grantA !== 1'b0) begin mismatched++; $display("[TB] FAIL rej_state: got %h/%b want 5a/0", txDataA, grantA); end
    tick();
    compared++; if (busyA !== 1'b0) begin mismatched++; $display("[TB] FAIL rej_no_late_select: got busy %b want 0", busyA); end
  endtask

  task automatic test_no_gap();
    int s, l, a; bit to;
    applyStimulus(1, 1, 0, 8'h3C, 8'hC3);
    tick();
    compared++; if ({loadB, ack0B, ack1B} !== 3'b110) begin mismatched++; $display("[TB] FAIL nogap_first: got %b want 110", {loadB, ack0B, ack1B}); end
    applyStimulus(1, 0, 1, 8'h3C, 8'hC3);
    runFrame(1, s, l, a, to);
    compared++; if (to !== 1'b0 || s !== 10) begin mismatched++; $display("[TB] FAIL nogap_strobes: got %0d timeout=%b want 10/0", s, to); end
    tick();
    compared++; if ({loadB, ack0B, ack1B} !== 3'b101) begin mismatched++; $display("[TB] FAIL nogap_pending: got %b want 101", {loadB, ack0B, ack1B}); end
    compared++; if (txDataB !== 8'hC3) begin mismatched++; $display("[TB] FAIL nogap_data: got %h want c3", txDataB); end
    applyStimulus(1, 0, 0, 8'h3C, 8'hC3);
    runFrame(1, s, l, a, to);
    compared++; if (to !== 1'b0 || s !== 10) begin mismatched++; $display("[TB] FAIL nogap_second: got %0d timeout=%b want 10/0", s, to); end
  endtask

  task automatic test_reset_mid();
    int s, l, a; bit hit, to;
    s = 0; hit = 1'b0;
    applyStimulus(0, 1, 0, 8'h77, 8'h00);
    tick();
    compared++; if ({loadA, ack0A} !== 2'b11) begin mismatched++; $display("[TB] FAIL mid_first_ack: got %b want 11", {loadA, ack0A}); end
    applyStimulus(0, 0, 0, 8'h77, 8'h00);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busyA && txen) s++;
      if (s == 5) begin hit = 1'b1; break; end
    end
    compared++; if (hit !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reach_5th: got %0d strobes want 5", s); end
    nRst = 1'b0;
    #1;
    compared++; if ({busyA, loadA, ack0A, ack1A} !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_outputs: got %b want 0000", {busyA, loadA, ack0A, ack1A}); end
    compared++; if (txDataA !== 8'h00 || grantA !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_regs: got %h/%b want 00/1", txDataA, grantA); end
    tick(); tick();
    compared++; if ({busyA, loadA, ack0A, ack1A} !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_held: got %b want 0000", {busyA, loadA, ack0A, ack1A}); end
    nRst = 1'b1;
    tick();
    applyStimulus(0, 1, 0, 8'h99, 8'h00);
    tick();
    compared++; if ({loadA, ack0A, ack1A} !== 3'b110 || txDataA !== 8'h99) begin mismatched++; $display("[TB] FAIL mid_restart: got %b/%h want 110/99", {loadA, ack0A, ack1A}, txDataA); end
    applyStimulus(0, 0, 0, 8'h99, 8'h00);
    runFrame(0, s, l, a, to);
    compared++; if (to !== 1'b0 || s !== 11) begin mismatched++; $display("[TB] FAIL mid_full_frame: got %0d timeout=%b want 11/0", s, to); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_busy_reject();
    test_no_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
